// File: rtl/reg8_arb_seq.sv
// reg8_arb_seq: round-robin front end for a shared load/increment register.
// Two requesters send LOAD or ADD-n commands over valid/ready. One command
// runs at a time. The controller drives the register's ld/inc/in pins cycle
// by cycle, then sends back the final register value tagged with the
// requester ID.
module reg8_arb_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_op,
  input  logic [DATA_W-1:0] req1_data,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic [DATA_W-1:0] reg_in,
  input  logic [DATA_W-1:0] reg_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_INC, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q;      // requester that wins when both are valid
  logic              id_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cnt_q;       // remaining increment cycles, counting down

  logic              grant_id;
  logic              grant_valid;
  logic              grant_op;
  logic [DATA_W-1:0] grant_data;
  logic              hs;

  // Arbitration and ready: combinational, active only while idle.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch is inferred.
    grant_id = prio_q;
    if (prio_q == 1'b0) grant_id = req0_valid ? 1'b0 : 1'b1;
    else                grant_id = req1_valid ? 1'b1 : 1'b0;
    grant_valid = grant_id ? req1_valid : req0_valid;
    grant_op    = grant_id ? req1_op    : req0_op;
    grant_data  = grant_id ? req1_data  : req0_data;
    hs          = (state_q == S_IDLE) && grant_valid;
    req0_ready  = hs && !grant_id;
    req1_ready  = hs &&  grant_id;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (hs) begin
        if (!grant_op)                state_d = S_LOAD;
        else if (grant_data != '0)    state_d = S_INC;
        else                          state_d = S_RESP;
      end
      S_LOAD: state_d = S_RESP;
      S_INC:  if (cnt_q == DATA_W'(1)) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, priority and latched command. Reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments, so every block samples pre-edge values.
      state_q <= state_d;
      if (hs) begin
        id_q   <= grant_id;
        data_q <= grant_data;
        cnt_q  <= grant_data;
        prio_q <= ~grant_id;
      end else if (state_q == S_INC) begin
        cnt_q <= cnt_q - DATA_W'(1);
      end
    end
  end

  // Registered outputs, computed from the upcoming state.
  // resp_data is loaded on the same edge that applies the last register update.
  // This controller is the register's only driver, so that update is known here.
  // The update is applied to the register's current value in advance.
  // As a result, resp_data equals reg_out throughout the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_ld     <= 1'b0;
      reg_inc    <= 1'b0;
      reg_in     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
    end else begin
      reg_ld     <= (state_d == S_LOAD);
      reg_inc    <= (state_d == S_INC);
      reg_in     <= (state_d == S_LOAD) ? grant_data : '0;
      resp_valid <= (state_d == S_RESP);
      if (state_d == S_RESP) begin
        resp_id <= (state_q == S_IDLE) ? grant_id : id_q;
        case (state_q)
          S_LOAD:  resp_data <= data_q;
          S_INC:   resp_data <= reg_out + DATA_W'(1);
          default: resp_data <= reg_out;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg8_arb_seq.sv
// Directed testbench for reg8_arb_seq, wired to a behavioural reg8 model.
module tb_reg8_arb_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_op = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req1_valid = 1'b0, req1_op = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_id;
  logic [7:0] resp_data;
  logic       reg_ld, reg_inc;
  logic [7:0] reg_in, reg_out;

  int checks = 0;
  int failures = 0;

  // Contention scenario: per-requester command lists and expected responses.
  logic       c0_op   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] c0_data [4] = '{8'h10, 8'h02, 8'h00, 8'h01};
  logic       c1_op   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] c1_data [4] = '{8'h01, 8'h80, 8'h03, 8'h00};
  logic       exp_id  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] exp_dat [8] = '{8'h10, 8'h11, 8'h13, 8'h80, 8'h80, 8'h83, 8'h84, 8'h84};

  always #5 clk = ~clk;

  // Behavioural model of the shared load/increment register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reg_out <= 8'h00;
    else if (reg_ld)  reg_out <= reg_in;
    else if (reg_inc) reg_out <= reg_out + 8'h01;
  end

  reg8_arb_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_in(reg_in), .reg_out(reg_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  // Present a command just after a rising edge and wait, bounded, for its handshake.
  task automatic issue(input bit id, input bit op, input logic [7:0] data, output int waited);
    bit got = 1'b0;
    waited = 0;
    @(posedge clk); #1;
    if (id == 1'b0) begin req0_valid = 1'b1; req0_op = op; req0_data = data; end
    else            begin req1_valid = 1'b1; req1_op = op; req1_data = data; end
    while (!got && waited < 50) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
      else waited++;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL issue_ready id=%0d: no ready within %0d cycles, required handshake", id, waited); end
    @(posedge clk); #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Wait, bounded, for the next response pulse.
  task automatic wait_resp(output int lat, output logic rid, output logic [7:0] rdata);
    bit got = 1'b0;
    lat = 0;
    while (!got && lat < 300) begin
      @(negedge clk); lat++;
      if (resp_valid) got = 1'b1;
    end
    rid = resp_id; rdata = resp_data;
    checks++;
    if (!got) begin failures++; $display("FAIL resp_timeout: no resp_valid within %0d cycles, required one", lat); end
  endtask

  // Wait, bounded, for a requester's ready while it already holds valid.
  task automatic wait_ready(input bit id, output bit got);
    int n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (reg_ld !== 1'b0)      begin failures++; $display("FAIL rst_reg_ld: got %b want 0", reg_ld); end
    checks++; if (reg_inc !== 1'b0)     begin failures++; $display("FAIL rst_reg_inc: got %b want 0", reg_inc); end
    checks++; if (reg_in !== 8'h00)     begin failures++; $display("FAIL rst_reg_in: got %h want 00", reg_in); end
    checks++; if (resp_valid !== 1'b0)  begin failures++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_id !== 1'b0)     begin failures++; $display("FAIL rst_resp_id: got %b want 0", resp_id); end
    checks++; if (resp_data !== 8'h00)  begin failures++; $display("FAIL rst_resp_data: got %h want 00", resp_data); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load();
    int w;
    issue(1'b0, 1'b0, 8'h5A, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL load_ready_same_cycle: waited %0d want 0", w); end
    @(negedge clk);
    checks++; if (reg_ld !== 1'b1)     begin failures++; $display("FAIL load_reg_ld: got %b want 1", reg_ld); end
    checks++; if (reg_in !== 8'h5A)    begin failures++; $display("FAIL load_reg_in: got %h want 5a", reg_in); end
    checks++; if (reg_inc !== 1'b0)    begin failures++; $display("FAIL load_reg_inc: got %b want 0", reg_inc); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL load_early_resp: got %b want 0", resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL load_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_id !== 1'b0)    begin failures++; $display("FAIL load_resp_id: got %b want 0", resp_id); end
    checks++; if (resp_data !== 8'h5A) begin failures++; $display("FAIL load_resp_data: got %h want 5a", resp_data); end
    checks++; if (reg_ld !== 1'b0)     begin failures++; $display("FAIL load_ld_one_cycle: got %b want 0", reg_ld); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL load_resp_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_add_wrap();
    int w, lat; logic rid; logic [7:0] rd;
    issue(1'b0, 1'b0, 8'hFE, w);
    wait_resp(lat, rid, rd);
    checks++; if (rd !== 8'hFE) begin failures++; $display("FAIL wrap_setup: got %h want fe", rd); end
    issue(1'b1, 1'b1, 8'h03, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({reg_inc, reg_ld} !== 2'b10) begin failures++; $display("FAIL wrap_inc_cycle%0d: inc,ld got %b want 10", k, {reg_inc, reg_ld}); end
    end
    @(negedge clk);
    checks++; if (reg_inc !== 1'b0)    begin failures++; $display("FAIL wrap_inc_count: got %b want 0 after 3 cycles", reg_inc); end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL wrap_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_id !== 1'b1)    begin failures++; $display("FAIL wrap_resp_id: got %b want 1", resp_id); end
    checks++; if (resp_data !== 8'h01) begin failures++; $display("FAIL wrap_resp_data: got %h want 01", resp_data); end
  endtask

  task automatic test_add_zero();
    int w, lat; logic rid; logic [7:0] rd;
    issue(1'b0, 1'b0, 8'h33, w);
    wait_resp(lat, rid, rd);
    issue(1'b0, 1'b1, 8'h00, w);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL add0_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_data !== 8'h33) begin failures++; $display("FAIL add0_resp_data: got %h want 33", resp_data); end
    checks++; if (resp_id !== 1'b0)    begin failures++; $display("FAIL add0_resp_id: got %b want 0", resp_id); end
    checks++; if ({reg_ld, reg_inc} !== 2'b00) begin failures++; $display("FAIL add0_no_pulse: ld,inc got %b want 00", {reg_ld, reg_inc}); end
  endtask

  task automatic drive_contention(input int i0, input int i1);
    req0_valid = (i0 < 4);
    if (i0 < 4) begin req0_op = c0_op[i0]; req0_data = c0_data[i0]; end
    req1_valid = (i1 < 4);
    if (i1 < 4) begin req1_op = c1_op[i1]; req1_data = c1_data[i1]; end
  endtask

  task automatic test_back_to_back();
    int i0 = 0, i1 = 0, ng = 0, nr = 0, cyc = 0, g;
    bit busy = 1'b0;
    do_reset();
    drive_contention(i0, i1);
    while (nr < 8 && cyc < 200) begin
      @(negedge clk); cyc++; g = 2;
      checks++; if (busy && (req0_ready || req1_ready)) begin failures++; $display("FAIL b2b_ready_busy: ready %b%b while busy, want 00", req0_ready, req1_ready); end
      checks++; if (req0_ready && req1_ready) begin failures++; $display("FAIL b2b_double_ready: both ready, want at most one"); end
      if (req0_ready) g = 0; else if (req1_ready) g = 1;
      if (resp_valid) begin
        checks++; if (resp_id !== exp_id[nr])    begin failures++; $display("FAIL b2b_resp_id%0d: got %b want %b", nr, resp_id, exp_id[nr]); end
        checks++; if (resp_data !== exp_dat[nr]) begin failures++; $display("FAIL b2b_resp_data%0d: got %h want %h", nr, resp_data, exp_dat[nr]); end
        nr++; busy = 1'b0;
      end
      if (g != 2) begin
        checks++;
        if (ng >= 8) begin failures++; $display("FAIL b2b_extra_grant: grant %0d beyond 8", ng); end
        else if (g[0] !== exp_id[ng]) begin failures++; $display("FAIL b2b_grant%0d: got %0d want %b", ng, g, exp_id[ng]); end
        ng++; busy = 1'b1;
      end
      @(posedge clk); #1;
      if (g == 0) i0++;
      if (g == 1) i1++;
      drive_contention(i0, i1);
    end
    checks++; if (nr != 8) begin failures++; $display("FAIL b2b_count: got %0d responses want 8", nr); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_prio_pass();
    int w, lat; logic rid; logic [7:0] rd; bit got;
    issue(1'b0, 1'b1, 8'h01, w);
    wait_resp(lat, rid, rd);
    issue(1'b1, 1'b0, 8'h10, w);
    wait_resp(lat, rid, rd);
    checks++; if ({rid, rd} !== {1'b1, 8'h10}) begin failures++; $display("FAIL prio_setup: id,data got %b,%h want 1,10", rid, rd); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 1'b1; req0_data = 8'h02;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 8'h01;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL prio_first_grant: ready0,1 got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1; req0_valid = 1'b0;
    wait_resp(lat, rid, rd);
    checks++; if ({rid, rd} !== {1'b0, 8'h12}) begin failures++; $display("FAIL prio_resp0: id,data got %b,%h want 0,12", rid, rd); end
    wait_ready(1'b1, got);
    checks++; if (!got) begin failures++; $display("FAIL prio_second_grant: req1 never ready, want ready"); end
    @(posedge clk); #1; req1_valid = 1'b0;
    wait_resp(lat, rid, rd);
    checks++; if ({rid, rd} !== {1'b1, 8'h13}) begin failures++; $display("FAIL prio_resp1: id,data got %b,%h want 1,13", rid, rd); end
  endtask

  task automatic test_reset_mid();
    int w, lat; logic rid; logic [7:0] rd; bit seen = 1'b0, got;
    issue(1'b0, 1'b1, 8'd200, w);
    repeat (5) @(negedge clk);
    checks++; if (reg_inc !== 1'b1) begin failures++; $display("FAIL rmid_inc_running: got %b want 1", reg_inc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (reg_inc !== 1'b0)    begin failures++; $display("FAIL rmid_async_inc: got %b want 0", reg_inc); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_async_resp: got %b want 0", resp_valid); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_no_resp: saw resp_valid after abort, want none"); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 8'h21;
    req1_valid = 1'b1; req1_op = 1'b0; req1_data = 8'h22;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL rmid_prio: ready0,1 got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1; req0_valid = 1'b0;
    wait_resp(lat, rid, rd);
    checks++; if ({rid, rd} !== {1'b0, 8'h21}) begin failures++; $display("FAIL rmid_resp0: id,data got %b,%h want 0,21", rid, rd); end
    wait_ready(1'b1, got);
    @(posedge clk); #1; req1_valid = 1'b0;
    wait_resp(lat, rid, rd);
    checks++; if ({rid, rd} !== {1'b1, 8'h22}) begin failures++; $display("FAIL rmid_resp1: id,data got %b,%h want 1,22", rid, rd); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_wrap();
    test_add_zero();
    test_back_to_back();
    test_prio_pass();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg8_arb_seq.md
Name: reg8_arb_seq

Overview:
- Two-requester controller that shares one reg8 load/increment register.
- Accepts LOAD and ADD-n commands over valid/ready handshakes and arbitrates round-robin between the requesters.
- Sequences the register's ld/inc controls cycle by cycle, then returns the resulting register value with the requester ID.
- Sits between the requesters and a single reg8 instance; it is the only driver of that register's ld, inc and in.

Parameters:
- DATA_W, 8: register, data and step-count width; must equal the width of the controlled register.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 command valid
- req0_ready  output  1  requester 0 command accepted
- req0_op  input  1  requester 0 opcode: 0=LOAD, 1=ADD
- req0_data  input  DATA_W  requester 0 load value (LOAD) or increment count (ADD)
- req1_valid  input  1  requester 1 command valid
- req1_ready  output  1  requester 1 command accepted
- req1_op  input  1  requester 1 opcode, same encoding as req0_op
- req1_data  input  DATA_W  requester 1 operand, same meaning as req0_data
- resp_valid  output  1  one-cycle completion pulse
- resp_id  output  1  ID of the requester being answered
- resp_data  output  DATA_W  register value after the operation
- reg_ld  output  1  drives register ld
- reg_inc  output  1  drives register inc
- reg_in  output  DATA_W  drives register in
- reg_out  input  DATA_W  register out

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - state IDLE; round-robin priority to req0.
  - reg_ld=0, reg_inc=0, reg_in=0.
  - resp_valid=0, resp_id=0, resp_data=0.
  - Step counter 0.
- Output timing:
  - reg_ld, reg_inc, reg_in and resp_* are registered.
  - Asynchronous reset clears them immediately, not at the next edge.
- FSM states: IDLE, LOAD, INC, RESP.
- IDLE:
  - reqX_ready is combinational: high only in IDLE, only for the granted requester, and only while that requester's valid is high.
  - Grant goes to the priority holder if its valid is high; otherwise to the other requester.
  - On handshake (valid & ready): latch op, data and id; priority passes to the non-granted requester.
  - op=0 goes to LOAD. op=1 with data≠0 goes to INC with counter=data. op=1 with data=0 goes directly to RESP.
- LOAD:
  - reg_ld=1 and reg_in=latched data for exactly one cycle, then RESP.
- INC:
  - reg_inc=1 every cycle; counter decrements each cycle.
  - Leave for RESP when counter==1, giving exactly n inc cycles.
  - reg_ld is never asserted together with reg_inc.
- RESP:
  - resp_valid=1 for one cycle; resp_data=reg_out, which already reflects the final register update; resp_id=latched id.
  - Then IDLE. There is no backpressure on the response.
- Latency, with handshake in cycle T:
  - LOAD: reg_ld in T+1, resp_valid in T+2.
  - ADD n≥1: reg_inc in T+1..T+n, resp_valid in T+n+1.
  - ADD 0: resp_valid in T+1.
- Throughput: one command in flight at a time; both ready outputs are low outside IDLE.
- Requester rules: a requester must hold valid, op and data stable until ready. The losing requester waits with no loss of its command.
- Arithmetic: the register wraps modulo 2^DATA_W (0xFF+1=0x00). The reported value is the wrapped value; no overflow flag.
- Simultaneous valid under sustained contention: grants strictly alternate 0,1,0,1...
- Reset mid-operation: the command is aborted, no response is issued, and priority returns to req0.

Test Plan:
- Reset, then req0_valid=1 with LOAD 0x5A -> req0_ready=1 in the same cycle; reg_ld=1 with reg_in=0x5A one cycle later; next cycle resp_valid=1, resp_id=0, resp_data=0x5A.
- Register at 0xFE, req1 ADD 3 -> reg_inc high exactly 3 consecutive cycles, reg_ld=0 throughout; resp_id=1, resp_data=0x01 (wrap).
- req0 ADD 0 with register at 0x33 -> no reg_ld/reg_inc pulse; resp_valid one cycle after handshake with resp_data=0x33.
- Both requesters hold valid across 4 commands each -> accepted order 0,1,0,1,...; a requester's ready is never high while another command is in progress.
- req1 alone issues LOAD 0x10, then both requesters valid -> req0 granted first, since priority passed to req0 after req1's grant.
- rst_n asserted mid-way through ADD 200 -> reg_inc falls asynchronously and no resp_valid appears; after release with both valid, req0 is granted first.
